uint8_mac_pe: RTL and testbench

- Output-stationary processing element for the uint8 systolic convolution array.
- Directly downstream of the uint8 register stage: it consumes registered activation (a) and weight (b) bytes.
- Forwards a east and b south after one registered cycle, for the next PE.
- Multiply-accumulates matched pairs; presents the finished dot product through a valid/ready handshake.

---
 rtl/uint8_sa_pkg.sv | 39 +++
 rtl/uint8_mac_pe_if.sv | 34 +++
 rtl/uint8_mul.sv | 12 +
 rtl/uint8_mac_pe.sv | 110 +++++++++++
 tb/tb_uint8_mac_pe.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/uint8_sa_pkg.sv
// Shared types, defaults and accumulate rule for the uint8 systolic array.
// Define UINT8_MAC_SAT_EN to make accumulation saturate instead of wrap.
package uint8_sa_pkg;

  parameter int unsigned DefDataW = 8;
  parameter int unsigned DefAccW  = 24;
  // Widest accumulator mac_add can serve; ACC_W must not exceed it.
  parameter int unsigned MaxAccW  = 48;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } pe_state_e;

  // Adds prod to acc within an acc_w-bit accumulator (both inputs already below 2^acc_w).
  function automatic logic [MaxAccW-1:0] mac_add(logic [MaxAccW-1:0] acc,
                                                 logic [MaxAccW-1:0] prod,
                                                 int unsigned        acc_w);
    logic [MaxAccW-1:0] mask;
`ifdef UINT8_MAC_SAT_EN
    logic [MaxAccW:0]   sum;
    mask = '1;
    mask = mask >> (MaxAccW - acc_w);
    sum  = {1'b0, acc} + {1'b0, prod};
    if (sum > {1'b0, mask}) begin
      return mask;
    end
    return sum[MaxAccW-1:0];
`else
    logic [MaxAccW-1:0] sum;
    mask = '1;
    mask = mask >> (MaxAccW - acc_w);
    sum  = acc + prod;
    return sum & mask;
`endif
  endfunction

endpackage

// File: rtl/uint8_mac_pe_if.sv
// Operand, forwarding and result-handshake signals of one systolic PE.
interface uint8_mac_pe_if
  import uint8_sa_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
);

  logic [DATA_W-1:0] a_in;
  logic              a_vld_in;
  logic [DATA_W-1:0] b_in;
  logic              b_vld_in;
  logic              start;
  logic              last;
  logic [DATA_W-1:0] a_out;
  logic              a_vld_out;
  logic [DATA_W-1:0] b_out;
  logic              b_vld_out;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_vld;
  logic              acc_rdy;
  logic              err;

  modport slave (
    input  a_in, a_vld_in, b_in, b_vld_in, start, last, acc_rdy,
    output a_out, a_vld_out, b_out, b_vld_out, acc_out, acc_vld, err
  );

  modport master (
    output a_in, a_vld_in, b_in, b_vld_in, start, last, acc_rdy,
    input  a_out, a_vld_out, b_out, b_vld_out, acc_out, acc_vld, err
  );

endinterface

// File: rtl/uint8_mul.sv
// Combinational unsigned DATA_W x DATA_W multiplier; drop-in point for a DSP primitive.
module uint8_mul #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0]   a_i,
  input  logic [DATA_W-1:0]   b_i,
  output logic [2*DATA_W-1:0] p_o
);

  assign p_o = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

endmodule

// File: rtl/uint8_mac_pe.sv
// Output-stationary uint8 MAC processing element with east/south operand forwarding.
// Build option: UINT8_MAC_SAT_EN selects saturating accumulation (see uint8_sa_pkg).
module uint8_mac_pe
  import uint8_sa_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input logic           clk,
  input logic           rst,
  uint8_mac_pe_if.slave pe
);

  logic [DATA_W-1:0]   a_q, b_q;
  logic                a_vld_q, b_vld_q;
  pe_state_e           state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                err_q, err_d;

  logic                fire, mism;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    load_val, sum_val;
  pe_state_e           restart_st;

  uint8_mul #(
    .DATA_W (DATA_W)
  ) u_mul (
    .a_i (pe.a_in),
    .b_i (pe.b_in),
    .p_o (prod)
  );

  assign fire       = pe.a_vld_in & pe.b_vld_in;
  assign mism       = pe.a_vld_in ^ pe.b_vld_in;
  // A start cycle may already carry the first pair, or even the whole (single-pair) product.
  assign load_val   = fire ? ACC_W'(prod) : '0;
  assign restart_st = (fire && pe.last) ? StDone : StAccum;
  assign sum_val    = ACC_W'(mac_add(MaxAccW'(acc_q), MaxAccW'(prod), ACC_W));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (pe.start) begin
          acc_d   = load_val;
          state_d = restart_st;
        end
      end
      StAccum: begin
        if (mism) err_d = 1'b1;
        if (pe.start) begin
          acc_d   = load_val;
          state_d = restart_st;
        end else if (fire) begin
          acc_d = sum_val;
          if (pe.last) state_d = StDone;
        end
      end
      StDone: begin
        // Result is held until accepted; start only counts alongside acceptance.
        if (pe.acc_rdy) begin
          if (pe.start) begin
            acc_d   = load_val;
            state_d = restart_st;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      a_vld_q <= 1'b0;
      b_q     <= '0;
      b_vld_q <= 1'b0;
    end else begin
      a_q     <= pe.a_in;
      a_vld_q <= pe.a_vld_in;
      b_q     <= pe.b_in;
      b_vld_q <= pe.b_vld_in;
    end
  end

  assign pe.a_out     = a_q;
  assign pe.a_vld_out = a_vld_q;
  assign pe.b_out     = b_q;
  assign pe.b_vld_out = b_vld_q;
  assign pe.acc_out   = acc_q;
  assign pe.acc_vld   = (state_q == StDone);
  assign pe.err       = err_q;

endmodule

// File: tb/tb_uint8_mac_pe.sv
// Self-checking bench for uint8_mac_pe: vector table, corner sequences and random traffic.
module tb_uint8_mac_pe;

  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 24;
  localparam int unsigned AW16 = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uint8_mac_pe_if #(.DATA_W(DW), .ACC_W(AW))   pe_if ();
  uint8_mac_pe_if #(.DATA_W(DW), .ACC_W(AW16)) pe16_if ();

  uint8_mac_pe #(.DATA_W(DW), .ACC_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .pe  (pe_if)
  );

  uint8_mac_pe #(.DATA_W(DW), .ACC_W(AW16)) dut16 (
    .clk (clk),
    .rst (rst),
    .pe  (pe16_if)
  );

  assign pe16_if.a_in     = pe_if.a_in;
  assign pe16_if.a_vld_in = pe_if.a_vld_in;
  assign pe16_if.b_in     = pe_if.b_in;
  assign pe16_if.b_vld_in = pe_if.b_vld_in;
  assign pe16_if.start    = pe_if.start;
  assign pe16_if.last     = pe_if.last;
  assign pe16_if.acc_rdy  = pe_if.acc_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the dot product in progress, for both accumulator widths.
  longint unsigned m_sum [2];
  int unsigned     m_w   [2];
  bit              m_active, m_done, m_err;
  logic [7:0]      m_a, m_b;
  logic            m_av, m_bv;

  typedef struct {
    logic [7:0]  a;
    logic        av;
    logic [7:0]  b;
    logic        bv;
    logic        st;
    logic        ls;
    logic        rdy;
    logic        e_vld;
    logic [23:0] e_acc;
    logic        e_err;
  } vec_t;

  vec_t tbl [10];

  function automatic longint unsigned ref_add(longint unsigned s, longint unsigned p,
                                              int unsigned w);
    longint unsigned lim;
    lim = 64'd1 << w;
`ifdef UINT8_MAC_SAT_EN
    return (s + p >= lim) ? lim - 1 : s + p;
`else
    return (s + p) % lim;
`endif
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic [7:0] a, logic av, logic [7:0] b, logic bv,
                       logic st, logic ls, logic rdy);
    pe_if.a_in     = a;
    pe_if.a_vld_in = av;
    pe_if.b_in     = b;
    pe_if.b_vld_in = bv;
    pe_if.start    = st;
    pe_if.last     = ls;
    pe_if.acc_rdy  = rdy;
  endtask

  // Advance one clock: update the model from the applied inputs, then compare.
  task automatic tick();
    bit              fire, take, was_rst;
    longint unsigned p;
    fire    = pe_if.a_vld_in && pe_if.b_vld_in;
    p       = longint'(pe_if.a_in) * longint'(pe_if.b_in);
    was_rst = rst;
    if (rst) begin
      m_sum    = '{0, 0};
      m_active = 0;
      m_done   = 0;
      m_err    = 0;
      m_a = 0; m_b = 0; m_av = 0; m_bv = 0;
    end else begin
      if (m_active && (pe_if.a_vld_in ^ pe_if.b_vld_in)) m_err = 1;
      take = pe_if.start && (!m_done || pe_if.acc_rdy);
      if (m_done && pe_if.acc_rdy) m_done = 0;
      if (take) begin
        for (int k = 0; k < 2; k++) m_sum[k] = fire ? p : 0;
        m_done   = fire && pe_if.last;
        m_active = !m_done;
      end else if (m_active && fire) begin
        for (int k = 0; k < 2; k++) m_sum[k] = ref_add(m_sum[k], p, m_w[k]);
        if (pe_if.last) begin
          m_active = 0;
          m_done   = 1;
        end
      end
      m_a = pe_if.a_in; m_b = pe_if.b_in; m_av = pe_if.a_vld_in; m_bv = pe_if.b_vld_in;
    end
    @(posedge clk);
    #1;
    check("a_out", 64'(pe_if.a_out), 64'(m_a));
    check("a_vld_out", 64'(pe_if.a_vld_out), 64'(m_av));
    check("b_out", 64'(pe_if.b_out), 64'(m_b));
    check("b_vld_out", 64'(pe_if.b_vld_out), 64'(m_bv));
    check("acc_vld", 64'(pe_if.acc_vld), 64'(m_done));
    check("acc_vld16", 64'(pe16_if.acc_vld), 64'(m_done));
    check("err", 64'(pe_if.err), 64'(m_err));
    if (m_done || was_rst) begin
      check("acc_out", 64'(pe_if.acc_out), 64'(m_sum[0]));
      check("acc_out16", 64'(pe16_if.acc_out), 64'(m_sum[1]));
    end
  endtask

  initial begin
    m_w = '{AW, AW16};
    tbl[0] = '{8'd1,  1, 8'd2,  1, 1, 0, 0, 0, 24'd0,   0};
    tbl[1] = '{8'd3,  1, 8'd4,  1, 0, 0, 0, 0, 24'd0,   0};
    tbl[2] = '{8'd5,  1, 8'd6,  1, 0, 1, 1, 1, 24'd44,  0};
    tbl[3] = '{8'd0,  0, 8'd0,  0, 0, 0, 1, 0, 24'd0,   0};
    tbl[4] = '{8'd10, 1, 8'd10, 1, 1, 0, 0, 0, 24'd0,   0};
    tbl[5] = '{8'd99, 1, 8'd0,  0, 0, 0, 0, 0, 24'd0,   1};
    tbl[6] = '{8'd2,  1, 8'd3,  1, 0, 0, 0, 0, 24'd0,   1};
    tbl[7] = '{8'd0,  0, 8'd77, 1, 0, 0, 0, 0, 24'd0,   1};
    tbl[8] = '{8'd4,  1, 8'd5,  1, 0, 1, 0, 1, 24'd126, 1};
    tbl[9] = '{8'd0,  0, 8'd0,  0, 0, 0, 1, 0, 24'd0,   1};

    rst = 1;
    drive(8'h3C, 1, 8'hC3, 1, 1, 1, 1);
    tick();
    tick();
    rst = 0;

    // Basic dot product (44) then a run with valid mismatches (100 + 6 + 20).
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].a, tbl[i].av, tbl[i].b, tbl[i].bv, tbl[i].st, tbl[i].ls, tbl[i].rdy);
      tick();
      check($sformatf("tbl%0d_vld", i), 64'(pe_if.acc_vld), 64'(tbl[i].e_vld));
      check($sformatf("tbl%0d_err", i), 64'(pe_if.err), 64'(tbl[i].e_err));
      if (tbl[i].e_vld) check($sformatf("tbl%0d_acc", i), 64'(pe_if.acc_out), 64'(tbl[i].e_acc));
    end

    // Overflow: 2 x 255*255 = 130050 in 24 bits; 16 bits wraps or clamps.
    rst = 1; drive(0, 0, 0, 0, 0, 0, 0); tick(); rst = 0;
    drive(8'd255, 1, 8'd255, 1, 1, 0, 0); tick();
    drive(8'd255, 1, 8'd255, 1, 0, 1, 0); tick();
    check("ovf_acc24", 64'(pe_if.acc_out), 64'd130050);
`ifdef UINT8_MAC_SAT_EN
    check("ovf_acc16", 64'(pe16_if.acc_out), 64'd65535);
`else
    check("ovf_acc16", 64'(pe16_if.acc_out), 64'd64514);
`endif
    drive(0, 0, 0, 0, 0, 0, 1); tick();

    // Backpressure: result held through pairs and start, then restart with acceptance.
    drive(8'd1, 1, 8'd2, 1, 1, 0, 0); tick();
    drive(8'd3, 1, 8'd4, 1, 0, 0, 0); tick();
    drive(8'd5, 1, 8'd6, 1, 0, 1, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(8'($urandom), 1, 8'($urandom), 1, 1, 1'($urandom), 0);
      tick();
      check("bp_vld", 64'(pe_if.acc_vld), 64'd1);
      check("bp_acc", 64'(pe_if.acc_out), 64'd44);
    end
    drive(8'd7, 1, 8'd8, 1, 1, 0, 1); tick();
    check("bp_drop", 64'(pe_if.acc_vld), 64'd0);
    drive(8'd1, 1, 8'd1, 1, 0, 1, 0); tick();
    check("bp_new", 64'(pe_if.acc_out), 64'd57);
    drive(0, 0, 0, 0, 0, 0, 1); tick();

    // Reset mid-operation, then a single-pair dot product.
    drive(8'd1, 1, 8'd1, 1, 1, 0, 0); tick();
    drive(8'd2, 1, 8'd2, 1, 0, 0, 0); tick();
    rst = 1;
    drive(8'hAA, 1, 8'h55, 1, 0, 0, 1); tick();
    rst = 0;
    check("rst_aout", 64'(pe_if.a_out), 64'd0);
    check("rst_vld", 64'(pe_if.acc_vld), 64'd0);
    check("rst_acc", 64'(pe_if.acc_out), 64'd0);
    drive(8'd7, 1, 8'd8, 1, 1, 1, 0); tick();
    check("rst_new_vld", 64'(pe_if.acc_vld), 64'd1);
    check("rst_new_acc", 64'(pe_if.acc_out), 64'd56);
    drive(0, 0, 0, 0, 0, 0, 1); tick();

    // Pass-through across IDLE/ACCUM/DONE with b_vld alternating.
    for (int i = 0; i < 10; i++) begin
      drive(8'(i), 1, 8'(9 - i), (i % 2) == 0, i == 0, i == 4, i >= 7);
      tick();
      check("pt_a", 64'(pe_if.a_out), 64'(i));
      check("pt_b", 64'(pe_if.b_out), 64'(9 - i));
      check("pt_bv", 64'(pe_if.b_vld_out), 64'((i % 2) == 0));
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(63) == 0);
      drive(8'($urandom), $urandom_range(3) != 0, 8'($urandom), $urandom_range(3) != 0,
            $urandom_range(9) == 0, $urandom_range(4) == 0, 1'($urandom));
      tick();
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
